// File: rtl/obi_peripheral_bridge.sv
// Registered OBI bridge: request register slice, credit counter and response FIFO.
// Optional watchdog enabled by defining OBI_PERIPHERAL_BRIDGE_TIMEOUT_EN.
module obi_peripheral_bridge #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int NoConfigBits   = 0
) (
    input  logic                                         UserCLK,
    input  logic                                         RESET_N,
    input  logic                                         REQ_top,
    input  logic                                         WE_top,
    input  logic [DATA_WIDTH/8-1:0]                      BE_top,
    input  logic [ADDR_WIDTH-1:0]                        ADDR_top,
    input  logic [DATA_WIDTH-1:0]                        WDATA_top,
    output logic                                         GNT_top,
    output logic                                         RVALID_top,
    output logic [DATA_WIDTH-1:0]                        RDATA_top,
    output logic                                         ERR_top,
    input  logic                                         RREADY_top,
    output logic                                         REQ,
    output logic                                         WE,
    output logic [DATA_WIDTH/8-1:0]                      BE,
    output logic [ADDR_WIDTH-1:0]                        ADDR,
    output logic [DATA_WIDTH-1:0]                        WDATA,
    input  logic                                         GNT,
    input  logic                                         RVALID,
    input  logic [DATA_WIDTH-1:0]                        RDATA,
    input  logic [(NoConfigBits > 0 ? NoConfigBits : 1)-1:0] ConfigBits
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                  req_valid;
    logic                  we_q;
    logic [BW-1:0]         be_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [CW-1:0] top_cnt;
    logic [CW-1:0] fab_cnt;

    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  top_hs;
    logic                  fab_hs;
    logic                  pop;
    logic                  push;
    logic                  empty;
    logic [DATA_WIDTH-1:0] push_data;

    // Pointers wrap modulo DEPTH; the top bit toggles on wrap to tell full from empty.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        logic [AW:0] n;
        if (p[AW-1:0] == AW'(DEPTH - 1)) begin
            n = {~p[AW], {AW{1'b0}}};
        end else begin
            n = p + 1'b1;
        end
        return n;
    endfunction

    assign GNT_top    = (!req_valid || GNT) && (top_cnt < DEPTH_C);
    assign top_hs     = REQ_top && GNT_top;
    assign fab_hs     = req_valid && GNT;
    assign empty      = (wptr == rptr);
    assign RVALID_top = !empty;
    assign pop        = RVALID_top && RREADY_top;
    assign RDATA_top  = mem[rptr[AW-1:0]];

    assign REQ   = req_valid;
    assign WE    = we_q;
    assign BE    = be_q;
    assign ADDR  = addr_q;
    assign WDATA = wdata_q;

`ifdef OBI_PERIPHERAL_BRIDGE_TIMEOUT_EN
    logic [15:0]   timer;
    logic [CW-1:0] drop_cnt;
    logic          fire;
    logic          err_mem [DEPTH];

    // A fabric response in the firing cycle takes priority over the timeout.
    assign fire      = (fab_cnt != '0) && !RVALID
                     && (timer == 16'(TIMEOUT_CYCLES - 1));
    assign push      = (RVALID && (fab_cnt != '0) && (drop_cnt == '0)) || fire;
    assign push_data = fire ? '0 : RDATA;
    assign ERR_top   = !empty && err_mem[rptr[AW-1:0]];

    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            timer <= '0;
        end else if ((fab_cnt == '0) || RVALID || fire) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            drop_cnt <= '0;
        end else if (fire) begin
            drop_cnt <= drop_cnt + 1'b1;
        end else if (RVALID && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) err_mem[i] <= 1'b0;
        end else if (push) begin
            err_mem[wptr[AW-1:0]] <= fire;
        end
    end
`else
    assign push      = RVALID && (fab_cnt != '0);
    assign push_data = RDATA;
    assign ERR_top   = 1'b0;
`endif

    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_valid <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (top_hs) begin
            req_valid <= 1'b1;
            we_q      <= WE_top;
            be_q      <= BE_top;
            addr_q    <= ADDR_top;
            wdata_q   <= WDATA_top;
        end else if (fab_hs) begin
            req_valid <= 1'b0;
        end
    end

    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            top_cnt <= '0;
        end else begin
            unique case ({top_hs, pop})
                2'b10:   top_cnt <= top_cnt + 1'b1;
                2'b01:   top_cnt <= top_cnt - 1'b1;
                default: top_cnt <= top_cnt;
            endcase
        end
    end

    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fab_cnt <= '0;
        end else begin
            unique case ({fab_hs, push})
                2'b10:   fab_cnt <= fab_cnt + 1'b1;
                2'b01:   fab_cnt <= fab_cnt - 1'b1;
                default: fab_cnt <= fab_cnt;
            endcase
        end
    end

    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
        end
    end

endmodule

// File: doc/obi_peripheral_bridge.md
# obi_peripheral_bridge

Registered, parametrised OBI bridge between the SoC-side OBI manager (`_top` ports, routed as FABulous EXTERNAL) and a peripheral implemented in the fabric user design. It decouples the two sides with a request register slice and a response FIFO. It supports up to DEPTH outstanding transactions and backpressure via RREADY_top. An optional watchdog can complete hung transactions with an error response.

## Interface
Parameters:
- ADDR_WIDTH, 24, address width
- DATA_WIDTH, 32, data width; multiple of 8
- DEPTH, 2, max outstanding transactions and response FIFO depth; power of two, 1..8
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; 1..65535; used only with the watchdog
- NoConfigBits, 0, FABulous config bit count

Ports:
- UserCLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- REQ_top, WE_top  in  1  request and write-enable from the SoC
- BE_top  in  DATA_WIDTH/8  byte enables
- ADDR_top  in  ADDR_WIDTH  address
- WDATA_top  in  DATA_WIDTH  write data
- GNT_top  out  1  grant to the SoC
- RVALID_top  out  1  response valid
- RDATA_top  out  DATA_WIDTH  response data
- ERR_top  out  1  error response (watchdog)
- RREADY_top  in  1  SoC accepts the response
- REQ, WE  out  1  request and write-enable to the fabric
- BE  out  DATA_WIDTH/8  byte enables to the fabric
- ADDR  out  ADDR_WIDTH  address to the fabric
- WDATA  out  DATA_WIDTH  write data to the fabric
- GNT  in  1  fabric grant
- RVALID  in  1  fabric response valid; the fabric has no rready
- RDATA  in  DATA_WIDTH  fabric response data
- ConfigBits  in  NoConfigBits  GLOBAL; unused

## Operation
- **Request slice:** one register holding {WE, BE, ADDR, WDATA} plus the flag req_valid.
  - REQ = req_valid; the fabric-side fields are driven from the register.
- **Credit counter:** `top_cnt` counts accepted transactions that have not yet popped; width is clog2(DEPTH+1).
- **Grant:** GNT_top = (!req_valid | GNT) & (top_cnt < DEPTH).
  - This is a combinational GNT-to-GNT_top path; it gives back-to-back throughput.
- **Top handshake** (REQ_top & GNT_top): loads the register, sets req_valid and increments top_cnt.
- **Fabric handshake** (REQ & GNT): clears req_valid unless it is reloaded in the same cycle. It increments `fab_cnt`, the count of transactions issued to the fabric and not yet answered.
- **Fabric response:** RVALID with fab_cnt > 0 and drop_cnt = 0 pushes {ERR=0, RDATA} into the FIFO and decrements fab_cnt.
  - RVALID with fab_cnt = 0 is spurious: it is discarded with no state change.
- **FIFO output:** RVALID_top = FIFO non-empty; RDATA_top and ERR_top show the FIFO head.
  - A pop (RVALID_top & RREADY_top) removes the head and decrements top_cnt.
- **Simultaneous events:**
  - A top handshake and a pop in the same cycle leave top_cnt unchanged.
  - Push and pop in the same cycle are allowed at any occupancy.
  - Credits guarantee the FIFO never overflows; the bench asserts push-when-full never occurs.
- **FIFO pointers:** wrap modulo DEPTH, with an extra bit for full/empty.
- **Outputs with no response pending:** RDATA_top = head storage (don't-care), ERR_top = 0.

## Timing
- **Reset values:**
  - REQ = 0, RVALID_top = 0, ERR_top = 0.
  - GNT_top = 1 (credit available, register empty).
  - All counters and pointers are 0; BE/ADDR/WDATA/RDATA_top are 0.
- **Request latency:** a top handshake at edge n puts REQ high in cycle n+1.
- **Response latency:** fabric RVALID in cycle m puts RVALID_top high in cycle m+1 (FIFO write-through, registered storage).
- **Holding:** RVALID_top, RDATA_top and ERR_top hold stable until popped.
- **Reset mid-operation:** everything is cleared asynchronously and in-flight transactions are lost.
  - Fabric responses arriving after reset are spurious and are discarded.

## Configuration
- **Macro:** `OBI_PERIPHERAL_BRIDGE_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit timer runs while fab_cnt > 0.
  - It clears on any fabric RVALID, on fab_cnt = 0, and after firing.
  - When it reaches TIMEOUT_CYCLES, the block pushes {ERR=1, RDATA=0}, decrements fab_cnt and increments drop_cnt.
  - While drop_cnt > 0, the next fabric RVALIDs are discarded and each decrements drop_cnt.
  - If RVALID and the timeout occur in the same cycle, RVALID wins and the timer clears.
- **Undefined:** no timer or drop_cnt; ERR_top is tied to 0.

## Test plan
- **Single transaction:** reset, then write ADDR_top=0x000010, WDATA_top=0xA5A5A5A5, BE=0xF; the fabric grants immediately and responds one cycle later.
  - REQ is high 1 cycle after the grant with the same fields.
  - RVALID_top is high 1 cycle after RVALID, with ERR_top=0.
- **Back-to-back reads, DEPTH=2:** fabric GNT constant 1 and RREADY_top=0.
  - Two grants are issued; GNT_top drops to 0 on the third request.
  - After one pop, GNT_top returns to 1.
- **Fabric backpressure:** GNT=0 for 5 cycles.
  - REQ and its fields stay stable.
  - GNT_top=0 while req_valid.
  - The transfer completes on the first cycle with GNT=1.
- **Response ordering:** fabric returns RDATA 0x1, then 0x2 on consecutive cycles, with RREADY_top toggling 0/1.
  - RDATA_top delivers 0x1 then 0x2, each popped exactly once.
- **Watchdog** (macro on, TIMEOUT_CYCLES=8): the fabric never responds.
  - RVALID_top and ERR_top are both high 9 cycles after the fabric handshake, with RDATA_top=0.
  - A late fabric RVALID is discarded.
- **Reset mid-flight:** assert RESET_N=0 with 2 outstanding transactions.
  - All outputs return to their reset values.
  - A later fabric RVALID produces no RVALID_top.
